// File: rtl/dm_rmw_ctrl_pkg.sv
// Shared definitions for the data-memory read-modify-write controller.
//   rmw_state_e : controller states (IDLE, MERGE = partial-store write phase,
//                 RDATA = load data phase)
//   BE_FULL     : byte-enable pattern of a full-word store
package dm_rmw_ctrl_pkg;

    typedef enum logic [1:0] {
        RMW_IDLE  = 2'd0,
        RMW_MERGE = 2'd1,
        RMW_RDATA = 2'd2
    } rmw_state_e;

    localparam logic [3:0] BE_FULL = 4'b1111;

endpackage

// File: rtl/dm_rmw_ctrl_byte_merge.sv
// Combinational byte merge for sub-word stores.
//   old_data : word read back from the RAM
//   new_data : lane-positioned store data
//   be       : byte enables; be[i]=1 takes byte i from new_data
//   merged   : word to write back
// The spec names the inputs old/new; "new" is a reserved word, hence the suffix.
module dm_byte_merge (
    input  logic [31:0] old_data,
    input  logic [31:0] new_data,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_data;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_rmw_ctrl.sv
// M-stage data-memory sequencer for a word-wide single-port synchronous RAM
// without byte-write enables.
//   clk, reset            : clock, asynchronous active-high reset
//   req, we, addr, byteen, wdata, flush : M-stage access (held while stall=1)
//   stall                 : hold M and upstream stages
//   rdata, rvalid         : loaded word, valid while rvalid=1
//   mem_addr, mem_re, mem_we, mem_wdata, mem_rdata : RAM interface
//                           (mem_rdata appears one cycle after mem_re)
//   dbg_state             : current FSM state, for observation only
// Handshake: an access is presented with req=1 and held unchanged while
// stall=1; it is complete in the first cycle with stall=0. flush kills the
// presented access in whatever cycle it is seen, and no write follows it.
module dm_rmw_ctrl
    import dm_rmw_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [3:0]        byteen,
    input  logic [31:0]       wdata,
    input  logic              flush,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output rmw_state_e        dbg_state
);

    rmw_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        byteen_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged;
    logic              enter_2c;

    // Byte offset and bits above the RAM size are not used: range checks are
    // upstream and out-of-range addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

    dm_byte_merge u_merge (
        .old_data (mem_rdata),
        .new_data (wdata_q),
        .be       (byteen_q),
        .merged   (merged)
    );

    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RMW_IDLE;
            addr_q   <= '0;
            byteen_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (enter_2c) begin
                addr_q <= addr[ADDR_W+1:2];
                if (we) begin
                    byteen_q <= byteen;
                    wdata_q  <= wdata;
                end
            end
        end
    end

    // Outputs are forced to their idle values while reset is held so that no
    // strobe reaches the RAM from a live request during reset.
    always_comb begin
        state_d   = state_q;
        enter_2c  = 1'b0;
        stall     = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_addr  = addr_q;
        if (reset) begin
            state_d  = RMW_IDLE;
            mem_addr = '0;
        end else begin
            case (state_q)
                RMW_IDLE: begin
                    mem_addr = addr[ADDR_W+1:2];
                    if (req && !flush) begin
                        if (we) begin
                            if (byteen == BE_FULL) begin
                                mem_we    = 1'b1;
                                mem_wdata = wdata;
                            end else if (byteen != 4'b0000) begin
                                mem_re   = 1'b1;
                                stall    = 1'b1;
                                enter_2c = 1'b1;
                                state_d  = RMW_MERGE;
                            end
                        end else begin
                            mem_re   = 1'b1;
                            stall    = 1'b1;
                            enter_2c = 1'b1;
                            state_d  = RMW_RDATA;
                        end
                    end
                end
                RMW_MERGE: begin
                    // The same instruction is still presented; only flush matters.
                    if (!flush) begin
                        mem_we    = 1'b1;
                        mem_wdata = merged;
                    end
                    state_d = RMW_IDLE;
                end
                RMW_RDATA: begin
                    if (!flush) begin
                        rvalid = 1'b1;
                        rdata  = mem_rdata;
                    end
                    state_d = RMW_IDLE;
                end
                default: state_d = RMW_IDLE;
            endcase
        end
    end

endmodule
